// File: rtl/lfsr_msg_encryptor_pkg.sv
// Shared types, constants and LFSR helpers for the message encryptor and its
// decrypt-side models.
// Contents: enc_state_t FSM states, PAD_CHAR, LFSR_PTRNS table, lfsr_step(), clamp_pre().
package lfsr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_PRE,
    S_RD_PTRN,
    S_RD_SEED,
    S_LATCH_SEED,
    S_RD_MSG,
    S_WR_MSG,
    S_DONE
  } enc_state_t;

  localparam logic [7:0] PAD_CHAR = 8'h20;

  // Known-good 7-bit tap patterns used by the program-3 flow.
  localparam logic [6:0] LFSR_PTRNS [9] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  // Shift left, feeding back the parity of the tapped bits into bit 0.
  function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] ptrn);
    return {s[5:0], ^(s & ptrn)};
  endfunction

  // Clamp the raw pre_length into [lo, hi]; callers pass only the low nibble.
  function automatic logic [6:0] clamp_pre(input logic [7:0] raw, input int lo, input int hi);
    int r;
    r = int'(raw);
    if (r < lo) r = lo;
    else if (r > hi) r = hi;
    return 7'(r);
  endfunction

endpackage

// File: rtl/lfsr_msg_encryptor_if.sv
// Control handshake and shared data-memory port of the encryptor.
// master: encryptor side (drives ack and DM strobes/address/wdata).
// slave:  top-level controller + memory side (drives req and dm_rdata).
interface lfsr_msg_encryptor_if;
  logic       req;
  logic       ack;
  logic [7:0] dm_addr;
  logic       dm_rd_en;
  logic [7:0] dm_rdata;
  logic       dm_wr_en;
  logic [7:0] dm_wdata;

  modport master (
    input  req, dm_rdata,
    output ack, dm_addr, dm_rd_en, dm_wr_en, dm_wdata
  );

  modport slave (
    output req, dm_rdata,
    input  ack, dm_addr, dm_rd_en, dm_wr_en, dm_wdata
  );
endinterface

// File: rtl/lfsr_msg_encryptor_lfsr7.sv
// 7-bit Fibonacci-style LFSR with programmable taps, parallel load and step enable.
// Ports: clk, init (sync reset), load/seed (load wins over step), step/ptrn, lfsr_state.
// Latency: loaded or stepped value visible the cycle after the strobe.
module lfsr7
  import lfsr_pkg::*;
(
  input  logic       clk,
  input  logic       init,
  input  logic       load,
  input  logic [6:0] seed,
  input  logic       step,
  input  logic [6:0] ptrn,
  output logic [6:0] lfsr_state
);

  always_ff @(posedge clk) begin
    if (init) begin
      lfsr_state <= '0;
    end else if (load) begin
      lfsr_state <= seed;
    end else if (step) begin
      lfsr_state <= lfsr_step(lfsr_state, ptrn);
    end
  end

endmodule

// File: rtl/lfsr_msg_encryptor.sv
// LFSR message encryptor: reads config + plaintext from data memory, prepends pad
// spaces, XORs (char - 0x20) with a 7-bit LFSR stream and writes OUT_LEN bytes back.
// Ports: clk, init (sync active-high reset), bus (lfsr_msg_encryptor_if.master: req/ack, DM port).
// Optional macro LFSR_PARITY_EN: enc[7] carries even parity of enc[6:0]; otherwise enc[7]=0.
module lfsr_msg_encryptor
  import lfsr_pkg::*;
#(
  parameter int MSG_BASE = 0,
  parameter int CFG_BASE = 61,
  parameter int OUT_BASE = 64,
  parameter int OUT_LEN  = 64,
  parameter int PRE_MIN  = 10,
  parameter int PRE_MAX  = 15
) (
  input  logic                  clk,
  input  logic                  init,
  lfsr_msg_encryptor_if.master  bus
);

  enc_state_t state, state_nxt;

  logic [6:0] pre;
  logic [6:0] ptrn;
  logic [6:0] idx;
  logic [6:0] lfsr_q;
  logic [6:0] seed_fix;
  logic [6:0] enc7;
  logic [7:0] plain;
  logic [7:0] enc;
  logic       lfsr_load;
  logic       lfsr_adv;
  logic       is_pad;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  assign seed_fix = (bus.dm_rdata[6:0] == 7'h00) ? 7'h01 : bus.dm_rdata[6:0];

  // idx is stable across the RD_MSG/WR_MSG pair, so is_pad is valid in both.
  assign is_pad = (idx < pre);
  assign plain  = is_pad ? PAD_CHAR : bus.dm_rdata;
  assign enc7   = 7'(plain - PAD_CHAR) ^ lfsr_q;

`ifdef LFSR_PARITY_EN
  assign enc = {^enc7, enc7};
`else
  assign enc = {1'b0, enc7};
`endif

  lfsr7 u_lfsr (
    .clk        (clk),
    .init       (init),
    .load       (lfsr_load),
    .seed       (seed_fix),
    .step       (lfsr_adv),
    .ptrn       (ptrn),
    .lfsr_state (lfsr_q)
  );

  // State register plus config/counter capture. Read data arrives one cycle
  // after the strobe, so each config field is captured in the following state.
  always_ff @(posedge clk) begin
    if (init) begin
      state <= S_IDLE;
      pre   <= '0;
      ptrn  <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_RD_PTRN:    pre  <= clamp_pre({4'h0, bus.dm_rdata[3:0]}, PRE_MIN, PRE_MAX);
        S_RD_SEED:    ptrn <= bus.dm_rdata[6:0];
        S_LATCH_SEED: idx  <= '0;
        S_WR_MSG:     idx  <= idx + 7'd1;
        default:      ;
      endcase
    end
  end

  // Next state and Moore outputs; everything idles at zero outside its state.
  always_comb begin
    state_nxt    = state;
    bus.ack      = 1'b0;
    bus.dm_addr  = 8'h00;
    bus.dm_rd_en = 1'b0;
    bus.dm_wr_en = 1'b0;
    bus.dm_wdata = 8'h00;
    lfsr_load    = 1'b0;
    lfsr_adv     = 1'b0;

    case (state)
      S_IDLE: begin
        if (!bus.req) state_nxt = S_RD_PRE;
      end
      S_RD_PRE: begin
        bus.dm_rd_en = 1'b1;
        bus.dm_addr  = 8'(CFG_BASE);
        state_nxt    = S_RD_PTRN;
      end
      S_RD_PTRN: begin
        bus.dm_rd_en = 1'b1;
        bus.dm_addr  = 8'(CFG_BASE + 1);
        state_nxt    = S_RD_SEED;
      end
      S_RD_SEED: begin
        bus.dm_rd_en = 1'b1;
        bus.dm_addr  = 8'(CFG_BASE + 2);
        state_nxt    = S_LATCH_SEED;
      end
      S_LATCH_SEED: begin
        lfsr_load = 1'b1;
        state_nxt = S_RD_MSG;
      end
      S_RD_MSG: begin
        // Pad positions need no memory access; the space is synthesised.
        if (!is_pad) begin
          bus.dm_rd_en = 1'b1;
          bus.dm_addr  = 8'(MSG_BASE) + {1'b0, idx - pre};
        end
        state_nxt = S_WR_MSG;
      end
      S_WR_MSG: begin
        bus.dm_wr_en = 1'b1;
        bus.dm_addr  = 8'(OUT_BASE) + {1'b0, idx};
        bus.dm_wdata = enc;
        lfsr_adv     = 1'b1;
        state_nxt    = (idx == 7'(OUT_LEN - 1)) ? S_DONE : S_RD_MSG;
      end
      S_DONE: begin
        bus.ack = 1'b1;
        if (bus.req) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lfsr_msg_encryptor.sv
// Self-checking bench for lfsr_msg_encryptor: behavioural data memory, scoreboard of
// expected writes, table of configurations plus abort / req-handshake sequences.
module tb_lfsr_msg_encryptor;

  localparam int OUT_BASE = 64;
  localparam int PRE_ADDR = 61;
  localparam string FULL_MSG = "  01234546789abcdefghijklmnopqrstuvwxyz. ";

  logic clk  = 1'b0;
  logic init = 1'b1;

  lfsr_msg_encryptor_if bus ();

  lfsr_msg_encryptor dut (
    .clk  (clk),
    .init (init),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  // Data memory with a back-door loader port; all writes happen here.
  logic [7:0] mem [256];
  logic       ld_en   = 1'b0;
  logic [7:0] ld_addr = 8'h00;
  logic [7:0] ld_data = 8'h00;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.dm_wr_en) mem[bus.dm_addr] <= bus.dm_wdata;
    if (bus.dm_rd_en) bus.dm_rdata <= mem[bus.dm_addr];
  end

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q [$];
  logic [7:0]  exp_bytes [64];

  typedef struct {
    logic [7:0] pre_raw;
    logic [7:0] ptrn;
    logic [7:0] seed;
    int         msg_sel;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic string msg_of(input int sel);
    if (sel == 1) return "A";
    if (sel == 2) return FULL_MSG;
    return "";
  endfunction

  function automatic logic [7:0] msg_byte(input string msg, input int a);
    if (a < msg.len()) return msg[a];
    return 8'h20;
  endfunction

  function automatic logic [6:0] tb_step(input logic [6:0] s, input logic [6:0] p);
    logic fb = 1'b0;
    for (int k = 0; k < 7; k++) fb = fb ^ (s[k] & p[k]);
    return {s[5:0], fb};
  endfunction

  function automatic int tb_pre(input logic [7:0] raw);
    int r = int'(raw[3:0]);
    return (r < 10) ? 10 : r;
  endfunction

  function automatic logic [6:0] tb_seed(input logic [7:0] raw);
    return (raw[6:0] == 7'h00) ? 7'h01 : raw[6:0];
  endfunction

  // Reference model: fills exp_bytes and pushes {addr,data} for every expected write.
  task automatic build_expected(input string msg, input logic [7:0] pre_raw,
                                input logic [7:0] ptrn, input logic [7:0] seed);
    logic [6:0] s;
    logic [7:0] plain;
    logic [6:0] e;
    int pre;
    pre = tb_pre(pre_raw);
    s   = tb_seed(seed);
    for (int i = 0; i < 64; i++) begin
      plain = (i < pre) ? 8'h20 : msg_byte(msg, i - pre);
      e     = 7'((plain - 8'h20) & 8'h7F) ^ s;
`ifdef LFSR_PARITY_EN
      exp_bytes[i] = {^e, e};
`else
      exp_bytes[i] = {1'b0, e};
`endif
      exp_q.push_back({8'(OUT_BASE + i), exp_bytes[i]});
      s = tb_step(s, ptrn[6:0]);
    end
  endtask

  task automatic load_mem(input string msg, input logic [7:0] pre_raw,
                          input logic [7:0] ptrn, input logic [7:0] seed);
    for (int a = 0; a < 128; a++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = 8'(a);
      if (a < PRE_ADDR)          ld_data = msg_byte(msg, a);
      else if (a == PRE_ADDR)     ld_data = pre_raw;
      else if (a == PRE_ADDR + 1) ld_data = ptrn;
      else if (a == PRE_ADDR + 2) ld_data = seed;
      else                        ld_data = 8'hEE;
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // One launch: drop req, watch every cycle, then close the req/ack handshake.
  // abort_at >= 0 pulses init while byte abort_at is being written.
  task automatic run_once(input int abort_at, input bit toggle_mid);
    int cyc = 0;
    int nw  = 0;
    int bad = 0;
    bit done = 1'b0;
    bit aborted = 1'b0;
    @(negedge clk);
    bus.req = 1'b0;
    while (!done && !aborted && cyc < 400) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      chk("rd_wr_exclusive", {31'b0, bus.dm_rd_en & bus.dm_wr_en}, 32'd0);
      if (toggle_mid && cyc == 40) bus.req = 1'b1;
      if (bus.dm_wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr=%0h data=%0h with empty scoreboard",
                   bus.dm_addr, bus.dm_wdata);
        end else begin
          chk("write_addr_data", {16'h0, bus.dm_addr, bus.dm_wdata}, {16'h0, exp_q.pop_front()});
        end
        if (abort_at >= 0 && bus.dm_addr == 8'(OUT_BASE + abort_at)) begin
          init    = 1'b1;
          bus.req = 1'b1;
          aborted = 1'b1;
        end
      end
      if (bus.ack) begin
        done = 1'b1;
        chk("latency", cyc, 32'd133);
      end
    end
    if (aborted) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort_ack", {31'b0, bus.ack}, 32'd0);
      chk("abort_wr_en", {31'b0, bus.dm_wr_en}, 32'd0);
      chk("abort_rd_en", {31'b0, bus.dm_rd_en}, 32'd0);
      init = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (bus.dm_wr_en || bus.dm_rd_en) nw++;
      end
      chk("abort_no_traffic", nw, 32'd0);
      for (int i = abort_at + 1; i < 64; i++)
        if (mem[OUT_BASE + i] !== 8'hEE) bad++;
      chk("abort_tail_untouched", bad, 32'd0);
      exp_q.delete();
    end else if (!done) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no ack after %0d cycles, required at 133", cyc);
    end else begin
      if (!toggle_mid) begin
        @(posedge clk);
        @(negedge clk);
        chk("ack_hold", {31'b0, bus.ack}, 32'd1);
      end
      bus.req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("ack_drop", {31'b0, bus.ack}, 32'd0);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
    end
  endtask

  task automatic decrypt_check(input string msg, input logic [7:0] pre_raw,
                               input logic [7:0] ptrn, input logic [7:0] seed);
    logic [6:0] s;
    logic [7:0] c;
    int pre;
    int bad = 0;
    pre = tb_pre(pre_raw);
    s   = tb_seed(seed);
    for (int i = 0; i < 64; i++) begin
      c = {1'b0, mem[OUT_BASE + i][6:0] ^ s} + 8'h20;
      if (i >= pre && c !== msg_byte(msg, i - pre)) bad++;
      s = tb_step(s, ptrn[6:0]);
    end
    chk("decrypt_roundtrip", bad, 32'd0);
  endtask

  vec_t vecs [6];
  logic [7:0] snap [64];

  initial begin
    int busy;
    int diff;
`ifdef LFSR_PARITY_EN
    vecs[0] = '{8'h0A, 8'h7E, 8'h36, 0, 8'h36, 8'h6C};
    vecs[1] = '{8'h0A, 8'h60, 8'h00, 0, 8'h81, 8'h82};
    vecs[2] = '{8'h03, 8'h48, 8'h55, 1, 8'h55, 8'h2B};
    vecs[3] = '{8'h1F, 8'h6A, 8'h7F, 1, 8'hFF, 8'h7E};
    vecs[4] = '{8'h0C, 8'h7E, 8'h36, 2, 8'h36, 8'h6C};
    vecs[5] = '{8'h0F, 8'hE0, 8'h80, 0, 8'h81, 8'h82};
`else
    vecs[0] = '{8'h0A, 8'h7E, 8'h36, 0, 8'h36, 8'h6C};
    vecs[1] = '{8'h0A, 8'h60, 8'h00, 0, 8'h01, 8'h02};
    vecs[2] = '{8'h03, 8'h48, 8'h55, 1, 8'h55, 8'h2B};
    vecs[3] = '{8'h1F, 8'h6A, 8'h7F, 1, 8'h7F, 8'h7E};
    vecs[4] = '{8'h0C, 8'h7E, 8'h36, 2, 8'h36, 8'h6C};
    vecs[5] = '{8'h0F, 8'hE0, 8'h80, 0, 8'h01, 8'h02};
`endif

    bus.req = 1'b1;
    init    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {31'b0, bus.ack}, 32'd0);
    chk("rst_rd_en", {31'b0, bus.dm_rd_en}, 32'd0);
    chk("rst_wr_en", {31'b0, bus.dm_wr_en}, 32'd0);
    chk("rst_addr", {24'b0, bus.dm_addr}, 32'd0);
    chk("rst_wdata", {24'b0, bus.dm_wdata}, 32'd0);
    init = 1'b0;

    busy = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.dm_rd_en || bus.dm_wr_en || bus.ack) busy++;
    end
    chk("idle_while_req_high", busy, 32'd0);

    foreach (vecs[v]) begin
      load_mem(msg_of(vecs[v].msg_sel), vecs[v].pre_raw, vecs[v].ptrn, vecs[v].seed);
      build_expected(msg_of(vecs[v].msg_sel), vecs[v].pre_raw, vecs[v].ptrn, vecs[v].seed);
      run_once(-1, 1'b0);
      chk($sformatf("vec%0d_byte0", v), {24'b0, mem[OUT_BASE]}, {24'b0, vecs[v].b0});
      chk($sformatf("vec%0d_byte1", v), {24'b0, mem[OUT_BASE + 1]}, {24'b0, vecs[v].b1});
      if (vecs[v].msg_sel != 0)
        decrypt_check(msg_of(vecs[v].msg_sel), vecs[v].pre_raw, vecs[v].ptrn, vecs[v].seed);
    end

    for (int p = 0; p < 9; p++) begin
      load_mem("", 8'h0A, {1'b0, lfsr_pkg::LFSR_PTRNS[p]}, 8'h36);
      build_expected("", 8'h0A, {1'b0, lfsr_pkg::LFSR_PTRNS[p]}, 8'h36);
      run_once(-1, 1'b0);
    end

    // req raised mid-run must not disturb the run.
    load_mem(FULL_MSG, 8'h0A, 8'h7E, 8'h36);
    build_expected(FULL_MSG, 8'h0A, 8'h7E, 8'h36);
    run_once(-1, 1'b1);
    decrypt_check(FULL_MSG, 8'h0A, 8'h7E, 8'h36);

    // Abort while writing byte 20, then a clean rerun.
    load_mem(FULL_MSG, 8'h0A, 8'h7E, 8'h36);
    build_expected(FULL_MSG, 8'h0A, 8'h7E, 8'h36);
    run_once(20, 1'b0);
    load_mem(FULL_MSG, 8'h0A, 8'h7E, 8'h36);
    build_expected(FULL_MSG, 8'h0A, 8'h7E, 8'h36);
    run_once(-1, 1'b0);
    decrypt_check(FULL_MSG, 8'h0A, 8'h7E, 8'h36);

    // Back-to-back runs on the same input produce identical output.
    for (int i = 0; i < 64; i++) snap[i] = mem[OUT_BASE + i];
    load_mem(FULL_MSG, 8'h0A, 8'h7E, 8'h36);
    build_expected(FULL_MSG, 8'h0A, 8'h7E, 8'h36);
    run_once(-1, 1'b0);
    diff = 0;
    for (int i = 0; i < 64; i++) if (mem[OUT_BASE + i] !== snap[i]) diff++;
    chk("rerun_identical", diff, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
